// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sharing arbiter.
//   - 4-bit ALU op-code constants (ALU_ADD .. ALU_SLTU) and ALU_OP_MAX.
//   - alu_op_t: op-code type carried on the request bus.
//   - state_e:  2-bit sequencer state encoding (IDLE/EXEC/RESP).
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'b0000;
    localparam alu_op_t ALU_SUB  = 4'b0001;
    localparam alu_op_t ALU_XOR  = 4'b0010;
    localparam alu_op_t ALU_OR   = 4'b0011;
    localparam alu_op_t ALU_AND  = 4'b0100;
    localparam alu_op_t ALU_SLL  = 4'b0101;
    localparam alu_op_t ALU_SRL  = 4'b0110;
    localparam alu_op_t ALU_SRA  = 4'b0111;
    localparam alu_op_t ALU_SLT  = 4'b1000;
    localparam alu_op_t ALU_SLTU = 4'b1001;

    // Highest legal op-code; anything above is reported through rsp_err.
    localparam alu_op_t ALU_OP_MAX = ALU_SLTU;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request/response bus between the two requesters and
// the shared-ALU arbiter.
//   req_valid/req_ready [1:0] : per-port request handshake
//   req_a*/req_b*/req_op*     : operands and op-code for port 0 and port 1
//   rsp_valid/rsp_ready [1:0] : per-port response handshake
//   rsp_result, rsp_err       : registered result and illegal-op flag
//   busy                      : arbiter is not idle
// Modports: master = requester side, slave = arbiter side.
interface alu_share_arb_if;
    import alu_pkg::*;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0;
    logic [31:0] req_b0;
    logic [31:0] req_a1;
    logic [31:0] req_b1;
    alu_op_t     req_op0;
    alu_op_t     req_op1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_err, busy
    );

endinterface

// File: rtl/alu_control.sv
// alu_control: RV32I integer ALU, combinational.
//   T      : propagation delay for behavioural views (no effect on logic)
//   a, b   : operands
//   op     : op-code from alu_pkg; illegal op-codes yield 0
//   result : 32-bit result
module alu_control
    import alu_pkg::*;
#(
    parameter real T = 0.0
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] result
);

    // A negative delay has no physical meaning; such an instance drives 0.
    if (T >= 0.0) begin : g_alu
        always_comb begin
            // NOTE: default assignment first so no path through the case leaves result unassigned (no latch).
            result = '0;
            case (op)
                ALU_ADD:  result = a + b;
                ALU_SUB:  result = a - b;
                ALU_XOR:  result = a ^ b;
                ALU_OR:   result = a | b;
                ALU_AND:  result = a & b;
                ALU_SLL:  result = a << b[4:0];
                ALU_SRL:  result = a >> b[4:0];
                ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
                ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
                ALU_SLTU: result = {31'b0, a < b};
                default:  result = '0;
            endcase
        end
    end else begin : g_alu_invalid
        assign result = '0;
    end

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant, purely combinational.
//   valid [1:0] : request vector
//   prio        : favoured port when both request
//   gnt   [1:0] : one-hot grant (zero when nothing requests)
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        if (valid == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end else begin
            gnt = valid;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one alu_control between the execute stage (port 0)
// and the address/CSR helper (port 1). One request is accepted at a time,
// its operands are latched, the ALU runs from the latches, and the result is
// returned to the granted port through a registered response.
//   T     : delay parameter forwarded to alu_control
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : alu_share_arb_if.slave (request/response handshakes, busy)
module alu_share_arb
    import alu_pkg::*;
#(
    parameter real T = 0.0
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_share_arb_if.slave bus
);

    state_e      state_q;
    logic        prio_q;
    logic        gnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    alu_op_t     op_q;
    logic [31:0] result_q;
    logic        err_q;
    logic [1:0]  rsp_valid_q;
    logic        busy_q;

    logic [1:0]  gnt;
    logic [31:0] alu_result;

    rr_arb2 u_arb (
        .valid (bus.req_valid),
        .prio  (prio_q),
        .gnt   (gnt)
    );

    alu_control #(.T(T)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result)
    );

    // Ready depends only on request valids, state and prio, never on rsp_ready.
    assign bus.req_ready  = (state_q == ST_IDLE) ? gnt : 2'b00;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: every register, operand latches included, is reset so an aborted transaction leaves nothing behind.
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            gnt_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so each register sees the other registers' pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        a_q     <= gnt[1] ? bus.req_a1  : bus.req_a0;
                        b_q     <= gnt[1] ? bus.req_b1  : bus.req_b0;
                        op_q    <= gnt[1] ? bus.req_op1 : bus.req_op0;
                        gnt_q   <= gnt[1];
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q    <= alu_result;
                    err_q       <= (op_q > ALU_OP_MAX);
                    rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the granted port's rsp_ready completes the response.
                    if (bus.rsp_ready[gnt_q]) begin
                        rsp_valid_q <= 2'b00;
                        busy_q      <= 1'b0;
                        prio_q      <= ~gnt_q;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: self-checking bench for alu_share_arb. A behavioural
// model (plain arithmetic ALU plus a round-robin favourite bit) supplies
// every expected value.
module tb_alu_share_arb;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   cyc;
    logic prio_m;

    alu_share_arb_if bus ();

    alu_share_arb #(.T(0.0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {err, result} from the ALU rules.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = b % 32;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a ^ b;
            4'd3: r = a | b;
            4'd4: r = a & b;
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            4'd7: r = a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: return {1'b1, 32'd0};
        endcase
        return {1'b0, r};
    endfunction

    function automatic int ref_winner(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 1 : 0;
        return v[1] ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction from IDLE to completion and returns what was seen.
    task automatic run_txn(
        input  logic [1:0]  v_start,
        input  logic [1:0]  v_after,
        input  logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
        input  logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
        input  int          hold,
        output logic [1:0]  ready_obs,
        output logic [1:0]  rv_obs,
        output logic [31:0] res_obs,
        output logic        err_obs,
        output bit          hold_ok,
        output bit          done_ok
    );
        bus.req_a0 = a0; bus.req_b0 = b0; bus.req_op0 = op0;
        bus.req_a1 = a1; bus.req_b1 = b1; bus.req_op1 = op1;
        bus.req_valid = v_start;
        bus.rsp_ready = 2'b00;
        #1;
        ready_obs = bus.req_ready;
        tick();
        bus.req_valid = v_after;
        #1;
        hold_ok = (bus.busy === 1'b1) && (bus.req_ready === 2'b00) && (bus.rsp_valid === 2'b00);
        tick();
        rv_obs  = bus.rsp_valid;
        res_obs = bus.rsp_result;
        err_obs = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            bus.rsp_ready = ~rv_obs;
            tick();
            if (bus.rsp_valid !== rv_obs || bus.rsp_result !== res_obs || bus.rsp_err !== err_obs ||
                bus.req_ready !== 2'b00 || bus.busy !== 1'b1)
                hold_ok = 0;
        end
        bus.rsp_ready = rv_obs;
        tick();
        bus.rsp_ready = 2'b00;
        done_ok = (bus.rsp_valid === 2'b00) && (bus.busy === 1'b0);
    endtask

    task automatic test_reset();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = '0;
        bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        prio_m = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b rsp_valid=%b req_ready=%b, want 0/00/00", bus.busy, bus.rsp_valid, bus.req_ready);
        end
        checks++;
        if (bus.rsp_result !== 32'd0 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: result=%h err=%b, want 0/0", bus.rsp_result, bus.rsp_err);
        end
    endtask

    task automatic test_port0_only();
        logic [1:0] rdy, rv; logic [31:0] res; logic err; bit hok, dok;
        run_txn(2'b01, 2'b00, 32'd7, 32'd5, 4'b0001, 32'd0, 32'd0, 4'd0, 0, rdy, rv, res, err, hok, dok);
        prio_m = 1'b1;
        checks++;
        if (rdy !== 2'b01 || rv !== 2'b01) begin
            errors++;
            $display("FAIL port0_handshake: req_ready=%b rsp_valid=%b, want 01/01", rdy, rv);
        end
        checks++;
        if (res !== 32'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL port0_sub: result=%h err=%b, want 00000002/0", res, err);
        end
        checks++;
        if (!hok || !dok) begin
            errors++;
            $display("FAIL port0_sequence: exec_ok=%0d done_ok=%0d, want 1/1", hok, dok);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] rdy, rv; logic [31:0] res; logic err; bit hok, dok;
        logic [32:0] exp; int w; int c_prev;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        prio_m = 1'b0;
        c_prev = -1;
        for (int n = 0; n < 4; n++) begin
            w = ref_winner(2'b11, prio_m);
            exp = (w == 0) ? ref_alu(4'b0111, 32'h8000_0000, 32'd4) : ref_alu(4'b1001, 32'd1, 32'hFFFF_FFFF);
            if (c_prev >= 0) begin
                checks++;
                if (cyc - c_prev !== 3) begin
                    errors++;
                    $display("FAIL alt_interval[%0d]: cycles=%0d, want 3", n, cyc - c_prev);
                end
            end
            c_prev = cyc;
            run_txn(2'b11, 2'b11, 32'h8000_0000, 32'd4, 4'b0111, 32'd1, 32'hFFFF_FFFF, 4'b1001, 0,
                    rdy, rv, res, err, hok, dok);
            checks++;
            if (rdy !== (2'b01 << w) || rv !== (2'b01 << w)) begin
                errors++;
                $display("FAIL alt_grant[%0d]: req_ready=%b rsp_valid=%b, want port %0d", n, rdy, rv, w);
            end
            checks++;
            if ({err, res} !== exp || !hok || !dok) begin
                errors++;
                $display("FAIL alt_result[%0d]: result=%h err=%b seq=%0d%0d, want %h/%b", n, res, err, hok, dok, exp[31:0], exp[32]);
            end
            prio_m = (w == 0);
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [1:0] rdy, rv; logic [31:0] res; logic err; bit hok, dok;
        run_txn(2'b01, 2'b10, 32'h1234_5678, 32'h0F0F_0F0F, 4'b0100, 32'd3, 32'd4, 4'b0000, 10,
                rdy, rv, res, err, hok, dok);
        checks++;
        if (rdy !== 2'b01 || rv !== 2'b01 || res !== 32'h0204_0608 || err !== 1'b0) begin
            errors++;
            $display("FAIL bp_result: ready=%b valid=%b result=%h err=%b, want 01/01/02040608/0", rdy, rv, res, err);
        end
        checks++;
        if (!hok || !dok) begin
            errors++;
            $display("FAIL bp_stable: hold_ok=%0d done_ok=%0d, want 1/1", hok, dok);
        end
        prio_m = 1'b1;
        run_txn(2'b10, 2'b00, 32'd0, 32'd0, 4'd0, 32'd3, 32'd4, 4'b0000, 0, rdy, rv, res, err, hok, dok);
        checks++;
        if (rdy !== 2'b10 || rv !== 2'b10 || res !== 32'd7) begin
            errors++;
            $display("FAIL bp_next_grant: ready=%b valid=%b result=%h, want 10/10/00000007", rdy, rv, res);
        end
        prio_m = 1'b0;
    endtask

    task automatic test_illegal_op();
        logic [1:0] rdy, rv; logic [31:0] res; logic err; bit hok, dok;
        run_txn(2'b10, 2'b00, 32'd0, 32'd0, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1100, 2,
                rdy, rv, res, err, hok, dok);
        checks++;
        if (rv !== 2'b10 || res !== 32'd0 || err !== 1'b1 || !hok) begin
            errors++;
            $display("FAIL illegal_op: valid=%b result=%h err=%b hold_ok=%0d, want 10/00000000/1/1", rv, res, err, hok);
        end
        run_txn(2'b10, 2'b00, 32'd0, 32'd0, 4'd0, 32'd1, 32'd2, 4'b0000, 0, rdy, rv, res, err, hok, dok);
        checks++;
        if (res !== 32'd3 || err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: result=%h err=%b, want 00000003/0", res, err);
        end
        prio_m = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [1:0] rdy, rv; logic [31:0] res; logic err; bit hok, dok;
        // Abort in EXEC.
        bus.req_a0 = 32'd5; bus.req_b0 = 32'd6; bus.req_op0 = 4'b0000;
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.rsp_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_exec: busy=%b valid=%b result=%h, want 0/00/00000000", bus.busy, bus.rsp_valid, bus.rsp_result);
        end
        // Abort in RESP.
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        tick();
        checks++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd11) begin
            errors++;
            $display("FAIL pre_reset_resp: valid=%b result=%h, want 01/0000000b", bus.rsp_valid, bus.rsp_result);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.rsp_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_resp: busy=%b valid=%b result=%h, want 0/00/00000000", bus.busy, bus.rsp_valid, bus.rsp_result);
        end
        prio_m = 1'b0;
        run_txn(2'b11, 2'b00, 32'd9, 32'd4, 4'b0001, 32'd1, 32'd1, 4'b0000, 0, rdy, rv, res, err, hok, dok);
        checks++;
        if (rdy !== 2'b01 || rv !== 2'b01 || res !== 32'd5 || !dok) begin
            errors++;
            $display("FAIL after_reset_txn: ready=%b valid=%b result=%h done=%0d, want 01/01/00000005/1", rdy, rv, res, dok);
        end
        prio_m = 1'b1;
    endtask

    task automatic test_operand_change();
        logic [1:0] rv;
        bus.req_a0 = 32'd1; bus.req_b0 = 32'd31; bus.req_op0 = 4'b0101;
        bus.req_valid = 2'b01;
        tick();
        bus.req_a0 = 32'h0000_0005;
        bus.req_b0 = 32'd0;
        bus.req_valid = 2'b00;
        tick();
        rv = bus.rsp_valid;
        checks++;
        if (rv !== 2'b01 || bus.rsp_result !== 32'h8000_0000) begin
            errors++;
            $display("FAIL operand_latch: valid=%b result=%h, want 01/80000000", rv, bus.rsp_result);
        end
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = 2'b00;
        prio_m = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0] rdy, rv; logic [31:0] res; logic err; bit hok, dok;
        logic [1:0] v; logic [31:0] a0, b0, a1, b1; logic [3:0] op0, op1;
        logic [32:0] exp; int w;
        for (int n = 0; n < 24; n++) begin
            v   = 2'($urandom_range(1, 3));
            a0  = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            op0 = 4'($urandom_range(0, 15));
            op1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) b0 = 32'($urandom_range(0, 40));
            w   = ref_winner(v, prio_m);
            exp = (w == 0) ? ref_alu(op0, a0, b0) : ref_alu(op1, a1, b1);
            run_txn(v, 2'($urandom_range(0, 3)), a0, b0, op0, a1, b1, op1, $urandom_range(0, 3),
                    rdy, rv, res, err, hok, dok);
            checks++;
            if (rdy !== (2'b01 << w) || rv !== (2'b01 << w) || {err, res} !== exp || !hok || !dok) begin
                errors++;
                $display("FAIL random[%0d]: ready=%b valid=%b result=%h err=%b seq=%0d%0d, want port %0d %h/%b",
                         n, rdy, rv, res, err, hok, dok, w, exp[31:0], exp[32]);
            end
            prio_m = (w == 0);
        end
        bus.req_valid = 2'b00;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        prio_m = 1'b0;
        test_reset();
        test_port0_only();
        test_alternate();
        test_backpressure();
        test_illegal_op();
        test_reset_mid();
        test_operand_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port, round-robin arbiter and sequencer that shares the single RV32I `alu_control` instance between the execute stage (port 0) and the address/CSR helper unit (port 1). It accepts one request at a time over a valid/ready handshake and latches the operands, then drives the ALU from registers. The result is returned to the granted requester through a registered valid/ready response with a tag. Sits in the datapath between both requesters and the ALU.

## Interface
- `T`, 0.000: propagation delay passed through to the instantiated `alu_control`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 2: bit i = requester i has a request.
- `req_ready` out 2: bit i = request i accepted this cycle; at most one bit set.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 32 each: operands for port 0 and port 1.
- `req_op0`, `req_op1` in 4 each: ALU op codes. Encoding: add 0000, sub 0001, xor 0010, or 0011, and 0100, sll 0101, srl 0110, sra 0111, slt 1000, sltu 1001.
- `rsp_valid` out 2: bit i = result pending for requester i; at most one bit set.
- `rsp_ready` in 2: bit i = requester i consumes the result.
- `rsp_result` out 32: registered ALU result.
- `rsp_err` out 1: latched op was 1010–1111; `rsp_result` = 0 in that case.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: `req_ready` = grant vector. On any `req_valid`, latch a/b/op of the winner and its index into `gnt_q` → EXEC.
  - EXEC: ALU inputs come from the latched registers. At the clock edge, capture the ALU result into `rsp_result` and set `rsp_err` = (op ≥ 1010) → RESP.
  - RESP: `rsp_valid[gnt_q]` = 1; `rsp_result` and `rsp_err` held stable. On `rsp_ready[gnt_q]`: toggle the priority pointer to ~`gnt_q` → IDLE.
- Round-robin arbitration:
  - Priority pointer `prio` (1 bit) names the favoured port.
  - If only one port is valid, that port wins.
  - If both are valid, port `prio` wins.
  - `prio` toggles only on response completion, so consecutive simultaneous requests alternate 0,1,0,1…
- `req_ready` is combinational from `req_valid`, state and `prio`. It is 0 outside IDLE.
- `rsp_ready` on the non-granted bit is ignored.
- `req_valid` dropping in EXEC or RESP has no effect; latched operands are used.
- ALU width rules are those of the ALU:
  - add/sub wrap modulo 2^32.
  - Shift amount = b[4:0].
  - slt/sltu return 0 or 1 in bit 0.

## Timing
- Reset (`rst_n`=0 at a rising edge): state IDLE, `prio`=0, `gnt_q`=0, latched operands 0, `rsp_result`=0, `rsp_err`=0. All outputs are then `req_ready`=0 (absent valid), `rsp_valid`=0, `busy`=0.
- Reset mid-operation: any EXEC or RESP transaction is discarded silently; no response is issued.
- Accept at edge N (IDLE, valid & ready) → EXEC during N+1 → `rsp_valid` high from cycle N+2.
- `rsp_valid` holds until the handshake edge M. IDLE begins at M+1, and a new accept is possible at edge M+1.
- Minimum issue interval: 3 cycles per operation.
- Simultaneous events:
  - Both valid in IDLE: grant goes to `prio`.
  - A new request arriving during RESP waits for IDLE. It is never lost while its `req_valid` is held.
- No combinational path from `rsp_ready` to `req_ready`.

## Structure
- Shared package `alu_pkg`:
  - 4-bit op-code constants (ALU_ADD … ALU_SLTU).
  - `ALU_OP_MAX` = 4'b1001.
  - FSM state encoding IDLE/EXEC/RESP (2 bits).
- Sub-modules:
  - One instantiated `alu_control #(.T(T))` fed from the latched registers.
  - A natural helper `rr_arb2` (inputs: 2-bit valid, prio; output: one-hot grant), purely combinational.
- Target size: ~150–250 lines of RTL.

## Test plan
- Port 0 only: a=7, b=5, op=0001, `rsp_ready` tied 1 → accepted at edge N; `rsp_valid`=2'b01 in cycle N+2 with `rsp_result`=2, `rsp_err`=0. Port 1 never sees ready or valid.
- Both valid every cycle (port 0 sra a=0x80000000 b=4; port 1 sltu a=1 b=0xFFFFFFFF):
  - Grants alternate 0,1,0,1.
  - Results are 0xF8000000 and 1.
  - `prio` reset → first grant is port 0.
- Response backpressure: hold `rsp_ready`=0 for 10 cycles after `rsp_valid` → result stable; `req_ready`=0 throughout despite a pending port-1 request; port 1 is granted the cycle after the handshake.
- Illegal op 1100 on port 1 with a=b=0xFFFFFFFF → `rsp_result`=0, `rsp_err`=1; the next legal op clears `rsp_err`.
- Reset asserted in EXEC and, separately, in RESP → next cycle `busy`=0, `rsp_valid`=0, `rsp_result`=0; a following request completes normally with port 0 priority.
- Operand change after accept: alter `req_a0` during EXEC → result reflects the accepted value (sll a=1 b=31 → 0x80000000).
